// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch/decode types, default widths and opcode constants.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} fetch_state_e;
   localparam int INSTR_W_DEF = 19;
   localparam int PC_W_DEF = 12;
   localparam int OPC_W = 6;
   localparam logic [OPC_W-1:0] HALT_OPC = 6'b111111;
   localparam logic [OPC_W-1:0] OPC_ALU = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_LOAD = 6'b010000;
   localparam logic [OPC_W-1:0] OPC_STORE = 6'b010001;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 6'b100000;
   localparam logic [OPC_W-1:0] OPC_JUMP = 6'b100001;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, decode and redirect signals of the fetch unit.
interface instr_fetch_unit_if import cpu_pkg::*; #(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_W = PC_W_DEF
);
   logic imem_req;
   logic [PC_W-1:0] imem_addr;
   logic imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0] instr_pc;
   logic instr_valid;
   logic instr_ready;
   logic redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic halted;
   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      input imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );
   modport slave (
      input imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifu_perf_counter.sv
// ifu_perf_counter: saturating event counter of width W.
module ifu_perf_counter #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/ack fetch, valid/ready issue to decode, redirect and HALT.
// Optional IFU_PERF_COUNTERS_EN adds fetch_count/squash_count outputs.
module instr_fetch_unit import cpu_pkg::*; #(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_W = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPC
) (
   input  logic clk,
   input  logic rst,
   instr_fetch_unit_if.master bus
`ifdef IFU_PERF_COUNTERS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] squash_count
`endif
);
   fetch_state_e state, state_n;
   logic [PC_W-1:0] pc, pc_n, instr_pc, instr_pc_n;
   logic [INSTR_W-1:0] instr, instr_n;
   logic imem_req, instr_valid, halted, redir;

   assign redir = bus.redirect_valid && state != HALTED;

   // Redirect outranks ack and ready, so a squashed word is never captured or issued.
   always_comb begin
      state_n = state;
      pc_n = pc;
      instr_n = instr;
      instr_pc_n = instr_pc;
      if (redir) begin
         pc_n = bus.redirect_pc;
         state_n = FETCH;
      end else if (state == IDLE) begin
         state_n = FETCH;
      end else if (state == FETCH && bus.imem_ack) begin
         instr_n = bus.imem_rdata;
         instr_pc_n = pc;
         pc_n = pc + 1'b1;
         state_n = HOLD;
      end else if (state == HOLD && bus.instr_ready) begin
         state_n = (instr[INSTR_W-1 -: OPC_W] == HALT_OPCODE) ? HALTED : FETCH;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         instr <= '0;
         instr_pc <= '0;
         imem_req <= 1'b0;
         instr_valid <= 1'b0;
         halted <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         instr <= instr_n;
         instr_pc <= instr_pc_n;
         imem_req <= state_n == FETCH;
         instr_valid <= state_n == HOLD;
         halted <= state_n == HALTED;
      end

   assign bus.imem_req = imem_req;
   assign bus.imem_addr = pc;
   assign bus.instr = instr;
   assign bus.instr_pc = instr_pc;
   assign bus.instr_valid = instr_valid;
   assign bus.halted = halted;

`ifdef IFU_PERF_COUNTERS_EN
   ifu_perf_counter #(.W(32)) u_fetch_cnt (
      .clk(clk),
      .rst(rst),
      .inc(instr_valid && bus.instr_ready && !redir),
      .count(fetch_count)
   );
   ifu_perf_counter #(.W(16)) u_squash_cnt (
      .clk(clk),
      .rst(rst),
      .inc(redir && (instr_valid || imem_req)),
      .count(squash_count)
   );
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus async-reset sequence for instr_fetch_unit.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hm = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;

   instr_fetch_unit_if bus ();

`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] fetch_count;
   logic [15:0] squash_count;
   instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus), .fetch_count(fetch_count), .squash_count(squash_count));
`else
   instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   // Memory acks every request in the same cycle; word = addr + 0x100, or HALT at 0 when hm=1.
   assign bus.imem_ack = bus.imem_req;
   assign bus.imem_rdata = (hm && bus.imem_addr == 12'h000) ? 19'h7E000 : 19'(bus.imem_addr) + 19'h100;

   typedef struct {
      logic ready;
      logic redir;
      logic [11:0] rpc;
      logic halt_mem;
      logic e_req;
      logic [11:0] e_addr;
      logic e_valid;
      logic [18:0] e_instr;
      logic [11:0] e_ipc;
      logic e_halted;
   } vec_t;

   vec_t vec[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rdy rd  rpc     hm  req addr    v  instr     ipc     hlt
      vec[0]  = '{1, 0, 12'h000, 0, 1, 12'h000, 0, 19'h00000, 12'h000, 0};
      vec[1]  = '{1, 0, 12'h000, 0, 0, 12'h001, 1, 19'h00100, 12'h000, 0};
      vec[2]  = '{1, 0, 12'h000, 0, 1, 12'h001, 0, 19'h00100, 12'h000, 0};
      vec[3]  = '{1, 0, 12'h000, 0, 0, 12'h002, 1, 19'h00101, 12'h001, 0};
      vec[4]  = '{1, 0, 12'h000, 0, 1, 12'h002, 0, 19'h00101, 12'h001, 0};
      vec[5]  = '{1, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[6]  = '{0, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[7]  = '{0, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[8]  = '{0, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[9]  = '{0, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[10] = '{0, 0, 12'h000, 0, 0, 12'h003, 1, 19'h00102, 12'h002, 0};
      vec[11] = '{1, 0, 12'h000, 0, 1, 12'h003, 0, 19'h00102, 12'h002, 0};
      vec[12] = '{1, 0, 12'h000, 0, 0, 12'h004, 1, 19'h00103, 12'h003, 0};
      vec[13] = '{0, 1, 12'h050, 0, 1, 12'h050, 0, 19'h00103, 12'h003, 0};
      vec[14] = '{0, 1, 12'h040, 0, 1, 12'h040, 0, 19'h00103, 12'h003, 0};
      vec[15] = '{1, 0, 12'h000, 0, 0, 12'h041, 1, 19'h00140, 12'h040, 0};
      vec[16] = '{1, 1, 12'h010, 0, 1, 12'h010, 0, 19'h00140, 12'h040, 0};
      vec[17] = '{0, 0, 12'h000, 0, 0, 12'h011, 1, 19'h00110, 12'h010, 0};
      vec[18] = '{0, 1, 12'hFFF, 1, 1, 12'hFFF, 0, 19'h00110, 12'h010, 0};
      vec[19] = '{0, 0, 12'h000, 1, 0, 12'h000, 1, 19'h010FF, 12'hFFF, 0};
      vec[20] = '{1, 0, 12'h000, 1, 1, 12'h000, 0, 19'h010FF, 12'hFFF, 0};
      vec[21] = '{0, 0, 12'h000, 1, 0, 12'h001, 1, 19'h7E000, 12'h000, 0};
      vec[22] = '{1, 0, 12'h000, 1, 0, 12'h001, 0, 19'h7E000, 12'h000, 1};
      vec[23] = '{1, 1, 12'h020, 1, 0, 12'h001, 0, 19'h7E000, 12'h000, 1};
      vec[24] = '{1, 1, 12'h030, 1, 0, 12'h001, 0, 19'h7E000, 12'h000, 1};

      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", 32'(bus.instr), 32'd0);
      chk("rst_ipc", 32'(bus.instr_pc), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'd0);

      for (int i = 0; i < 25; i++) begin
         bus.instr_ready = vec[i].ready;
         bus.redirect_valid = vec[i].redir;
         bus.redirect_pc = vec[i].rpc;
         hm = vec[i].halt_mem;
         step();
         chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(vec[i].e_req));
         chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(vec[i].e_addr));
         chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vec[i].e_valid));
         chk($sformatf("v%0d_instr", i), 32'(bus.instr), 32'(vec[i].e_instr));
         chk($sformatf("v%0d_ipc", i), 32'(bus.instr_pc), 32'(vec[i].e_ipc));
         chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(vec[i].e_halted));
      end

`ifdef IFU_PERF_COUNTERS_EN
      chk("fetch_count", fetch_count, 32'd5);
      chk("squash_count", 32'(squash_count), 32'd4);
`endif

      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1) begin
            chk("halt_stays", {30'd0, bus.imem_req, bus.halted}, 32'd1);
            break;
         end
      end

      // Async reset mid-cycle while holding an instruction.
      bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b0;
      hm = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      step();
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", 32'(bus.instr), 32'h100);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.instr_valid), 32'd0);
      chk("arst_halted", 32'(bus.halted), 32'd0);
      chk("arst_instr", 32'(bus.instr), 32'd0);
      chk("arst_addr", 32'(bus.imem_addr), 32'd0);
`ifdef IFU_PERF_COUNTERS_EN
      chk("arst_fetch_count", fetch_count, 32'd0);
      chk("arst_squash_count", 32'(squash_count), 32'd0);
`endif
      step();
      rst = 1'b0;
      step();
      chk("restart_req", 32'(bus.imem_req), 32'd1);
      chk("restart_addr", 32'(bus.imem_addr), 32'd0);
      step();
      chk("restart_instr", 32'(bus.instr), 32'h100);
      chk("restart_ipc", 32'(bus.instr_pc), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
